// File: rtl/ram_port_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_sequencer_pkg
// Shared definitions for the RAM port sequencer:
//   - command opcodes as carried on CMD_OP / RSP_OP
//   - sequencer FSM state encoding
//   - response record layout helper ({data, op, err})
// ---------------------------------------------------------------------------
package ram_port_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ADD   = 2'd2,
        OP_RSV   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CAP  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Response record = data word + 2-bit op echo + 1-bit error flag.
    localparam int RSP_META_W = 3;

    function automatic int rsp_rec_w(input int data_w);
        return data_w + RSP_META_W;
    endfunction

endpackage

// File: rtl/ram_port_sequencer_fifo.sv
// ---------------------------------------------------------------------------
// ram_rsp_fifo
// Synchronous FIFO buffering response records for the RAM port sequencer.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (control only)
//   push, din       write request and record
//   pop             read request (ignored when empty)
//   dout            head record, forced to zero while empty
//   full, empty     status flags
//   count           number of stored records (0..DEPTH)
// ---------------------------------------------------------------------------
module ram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 35
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign push_en = push && (!full || pop);
    assign pop_en  = pop && !empty;
    // Zeroed head while empty keeps the response outputs at a defined value
    // without having to reset the storage array.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_port_sequencer.sv
// ---------------------------------------------------------------------------
// ram_port_sequencer
// Initiator for one port of a dual-port RAM with registered, read-before-write
// output. Executes READ, WRITE and ADD (mem += wdata) commands one at a time
// and returns the pre-operation word on a buffered response stream.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   CMD_VALID/READY/OP/ADDR/WDATA  command stream (READY from state/count only)
//   RSP_VALID/READY/DATA/OP/ERR    response stream, driven from buffer head
//   RAM_ADDR/WE/DIN                registered RAM port drive
//   RAM_Q                          RAM registered read data
//   BUSY                           a command is in flight
// ---------------------------------------------------------------------------
module ram_port_sequencer
    import ram_port_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [1:0]        RSP_OP,
    output logic              RSP_ERR,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [DATA_W-1:0] RAM_DIN,
    input  logic [DATA_W-1:0] RAM_Q,
    output logic              BUSY
);

    localparam int REC_W = rsp_rec_w(DATA_W);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    state_e            state;
    state_e            state_nxt;
    op_e               op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;

    logic              cmd_acc;
    logic              fifo_push;
    logic [REC_W-1:0]  fifo_din;
    logic [REC_W-1:0]  fifo_dout;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full_unused;

    // The add result deliberately wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign CMD_READY        = (state == ST_IDLE) && (fifo_count < CNT_W'(RSP_DEPTH));
    assign cmd_acc          = CMD_VALID && CMD_READY;
    assign BUSY             = (state != ST_IDLE);
    assign fifo_pop         = RSP_VALID && RSP_READY;
    assign RSP_VALID        = !fifo_empty;
    assign fifo_full_unused = fifo_full;
    assign {RSP_DATA, RSP_OP, RSP_ERR} = fifo_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_push = 1'b0;
        fifo_din  = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_acc) state_nxt = ST_ACC;
            end
            ST_ACC: begin
                state_nxt = ST_CAP;
            end
            ST_CAP: begin
                // RAM_Q now holds the word as it was before this command.
                if (op_q == OP_ADD) begin
                    state_nxt = ST_WB;
                end else begin
                    fifo_push = 1'b1;
                    fifo_din  = {RAM_Q, op_q, (op_q == OP_RSV)};
                    state_nxt = ST_IDLE;
                end
            end
            ST_WB: begin
                fifo_push = 1'b1;
                fifo_din  = {old_q, op_q, 1'b0};
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // RAM drive registers. Asynchronous reset pulls RAM_WE low at once, so an
    // ADD interrupted in WB never writes its sum back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_READ;
            RAM_ADDR <= '0;
            RAM_WE   <= 1'b0;
            RAM_DIN  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_acc) begin
                        op_q     <= op_e'(CMD_OP);
                        RAM_ADDR <= CMD_ADDR;
                        RAM_DIN  <= CMD_WDATA;
                        RAM_WE   <= (CMD_OP == OP_WRITE);
                    end
                end
                ST_ACC: begin
                    RAM_WE <= 1'b0;
                end
                ST_CAP: begin
                    if (op_q == OP_ADD) begin
                        RAM_DIN <= wrap_add(RAM_Q, wdata_q);
                        RAM_WE  <= 1'b1;
                    end
                end
                ST_WB: begin
                    RAM_WE <= 1'b0;
                end
                default: RAM_WE <= 1'b0;
            endcase
        end
    end

    // Data-only registers: no reset needed, always loaded before use.
    always_ff @(posedge clk) begin
        if (cmd_acc)          wdata_q <= CMD_WDATA;
        if (state == ST_CAP)  old_q   <= RAM_Q;
    end

    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (REC_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ram_port_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ram_port_sequencer
// Self-checking bench: a behavioural RAM drives RAM_Q, a word-level memory
// model predicts every response in order, directed scenarios check latency,
// back-pressure and reset behaviour, and a randomized phase mixes ops.
// ---------------------------------------------------------------------------
module tb_ram_port_sequencer;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 32;
    localparam int RSP_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_op;
    logic              rsp_err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_q;
    logic              busy;

    always #5 clk = ~clk;

    ram_port_sequencer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_OP    (cmd_op),
        .CMD_ADDR  (cmd_addr),
        .CMD_WDATA (cmd_wdata),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_DATA  (rsp_data),
        .RSP_OP    (rsp_op),
        .RSP_ERR   (rsp_err),
        .RAM_ADDR  (ram_addr),
        .RAM_WE    (ram_we),
        .RAM_DIN   (ram_din),
        .RAM_Q     (ram_q),
        .BUSY      (busy)
    );

    // Behavioural RAM port: registered read-before-write output.
    logic [DATA_W-1:0] ram [8];
    always @(posedge clk) begin
        ram_q <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_din;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: memory image plus in-order queue of expected responses.
    logic [DATA_W-1:0] ref_mem [8];
    logic [34:0]       exp_q [$];
    logic [34:0]       m_exp;
    logic [DATA_W-1:0] m_old;
    logic [DATA_W-1:0] last_data;
    logic [1:0]        last_op;
    logic              last_err;
    int                cyc = 0;
    int                acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                m_old = ref_mem[cmd_addr];
                if (cmd_op == 2'd1) ref_mem[cmd_addr] = cmd_wdata;
                if (cmd_op == 2'd2) ref_mem[cmd_addr] = m_old + cmd_wdata;
                exp_q.push_back({m_old, cmd_op, (cmd_op == 2'd3)});
                chk("occupancy", (exp_q.size() <= RSP_DEPTH), 1);
                acc_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    m_exp = exp_q.pop_front();
                    chk("rsp_data", rsp_data, m_exp[34:3]);
                    chk("rsp_op",   rsp_op,   m_exp[2:1]);
                    chk("rsp_err",  rsp_err,  m_exp[0]);
                end
                last_data = rsp_data;
                last_op   = rsp_op;
                last_err  = rsp_err;
            end
        end
    end

    task automatic drive_cmd(input logic [1:0] op, input logic [2:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [31:0] d);
        drive_cmd(op, a, d);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", (busy || exp_q.size() != 0), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt;
        int blocked;
        int prev_acc;
        logic [1:0] prev_op;
        logic [1:0] op;
        logic [2:0] a;
        bit tog_en;
        bit seen_valid;

        for (int i = 0; i < 8; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        #1 rst_n  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data",  rsp_data,  0);
        chk("rst_rsp_op",    rsp_op,    0);
        chk("rst_rsp_err",   rsp_err,   0);
        chk("rst_ram_we",    ram_we,    0);
        chk("rst_ram_addr",  ram_addr,  0);
        chk("rst_ram_din",   ram_din,   0);
        chk("rst_busy",      busy,      0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // WRITE then READ with 3-cycle response latency
        issue(2'd1, 3'd5, 32'hDEADBEEF);
        drain();
        chk("wr_rsp_op", last_op, 1);
        issue(2'd0, 3'd5, 32'h0);
        @(negedge clk) chk("rd_lat_c1", rsp_valid, 0);
        @(negedge clk) chk("rd_lat_c2", rsp_valid, 0);
        @(negedge clk) chk("rd_lat_c3", rsp_valid, 1);
        chk("rd_data", rsp_data, 32'hDEADBEEF);
        drain();

        // ADD with wrap: write-enable pulses once, response after 4 cycles
        issue(2'd1, 3'd2, 32'hFFFFFFFF);
        drain();
        issue(2'd2, 3'd2, 32'h3);
        we_cnt = 0;
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
            if (i == 2) chk("add_lat_c3", rsp_valid, 0);
            if (i == 3) seen_valid = rsp_valid;
        end
        chk("add_we_pulses", we_cnt, 1);
        chk("add_lat_c4", seen_valid, 1);
        drain();
        chk("add_old", last_data, 32'hFFFFFFFF);
        issue(2'd0, 3'd2, 32'h0);
        drain();
        chk("add_wrap", last_data, 32'h2);

        // Reserved op: read with error flag, no write
        issue(2'd3, 3'd1, $urandom);
        we_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
        end
        chk("rsv_no_we", we_cnt, 0);
        drain();
        chk("rsv_err", last_err, 1);
        chk("rsv_data", last_data, ref_mem[1]);

        // Back-pressure: two complete, third held until responses drain
        #0 rsp_ready = 1'b0;
        issue(2'd0, 3'd6, 32'h0);
        issue(2'd0, 3'd7, 32'h0);
        drive_cmd(2'd0, 3'd0, 32'h0);
        blocked = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_ready) blocked++;
        end
        chk("bp_ready_low", blocked, 0);
        chk("bp_pending", exp_q.size(), 2);
        chk("bp_rsp_valid", rsp_valid, 1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_accept();
        drain();

        // Reset during WB of an ADD: write-back suppressed, no response
        issue(2'd1, 3'd4, 32'h10);
        drain();
        issue(2'd2, 3'd4, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wb_we_before_rst", ram_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_we_drop", ram_we, 0);
        chk("rst_busy_drop", busy, 0);
        chk("rst_no_rsp", rsp_valid, 0);
        exp_q.delete();
        ref_mem[4] = 32'h10;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(2'd0, 3'd4, 32'h0);
        drain();
        chk("rst_add_dropped", last_data, 32'h10);

        // Back-to-back mixed ops over all addresses: no buffer stalls
        prev_acc = 0;
        prev_op  = 2'd0;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 3'((i * 3 + 1) % 8);
            issue(op, a, $urandom);
            if (i > 0) chk("b2b_gap", acc_cyc - prev_acc, (prev_op == 2'd2) ? 4 : 3);
            prev_acc = acc_cyc;
            prev_op  = op;
        end
        drain();

        // Randomized ops with random response back-pressure
        tog_en = 1'b1;
        fork
            begin
                while (tog_en) begin
                    @(posedge clk);
                    #1 rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom);
        end
        tog_en = 1'b0;
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        drain();
        chk("final_empty", exp_q.size(), 0);
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
